dnn_batch_seq: RTL and testbench
================================

# dnn_batch_seq

Hardware batch sequencer for the `dnn_relu_fp16` inference engine.
- Steps the test-case memory, starts the engine and waits for its done signal.
- Runs a sequential arg-max over the 10 signed outputs and compares the predicted class with the memory's expected label.
- Accumulates hit and test-case counts.
- Replaces the software loop around the engine, so accuracy runs need no bench-side scoring.

## Interface
- `N_TC`, 5000: test cases per batch (≥1).
- `N_OUT`, 10: engine output count.
- `OUT_W`, 16: signed output width.
- `LBL_W`, 32: expected-label width.
- `TIMEOUT_CYC`, 65536: watchdog limit in cycles, used only with the macro.
- `CNT_W`, `$clog2(N_TC+1)`: counter width (derived).
- `clk` in 1: sole clock; all logic is posedge.
- `rst` in 1: reset. Asynchronous, active-low.
- `run` in 1: start a batch; sampled in IDLE only.
- `abort` in 1: terminate the batch.
- `busy` out 1: high in every state except IDLE.
- `batch_done` out 1: one-cycle pulse at the end of a full batch.
- `tc_next` out 1: one-cycle pulse that advances the test-case memory.
- `dnn_start` out 1: one-cycle engine start pulse.
- `dnn_reset` out 1: one-cycle engine clear pulse.
- `dnn_done` in 1: engine done level.
- `dnn_out[N_OUT]` in `OUT_W` signed: engine scores.
- `exp_y` in `LBL_W`: expected class, 1-based.
- `hit_count` out `CNT_W`: number of correct predictions.
- `tc_count` out `CNT_W`: number of completed test cases.
- `last_pred` out `LBL_W`: most recent predicted class.
- `timeout_cnt` out `CNT_W`: number of watchdog expiries.

## Operation
- FSM states: IDLE, NEXT, START, WAIT, ARGMAX, SCORE, CLEAR, DONE.
- IDLE: when `run`=1, clear `hit_count` and `tc_count`, then go to NEXT. When `run`=0, stay in IDLE.
- NEXT: assert `tc_next` for this cycle, then go to START.
- START: assert `dnn_start` for this cycle, then go to WAIT.
- WAIT: stay until a rising edge of `dnn_done` is seen (`dnn_done & ~done_q`), then go to ARGMAX.
  - `done_q` is registered every cycle.
  - A level that is already high on entry is not an edge.
- ARGMAX: examine one output per cycle, index 0..N_OUT-1, which takes N_OUT cycles.
  - Accumulator starts with `best`=0 and `pred`=0.
  - Update only when `dnn_out[i] > best`, which is a strict signed compare. Ties therefore keep the lowest index.
  - On update, set `pred`=i+1.
  - If no score is positive, `pred`=0.
  - Next state is SCORE.
- SCORE: `last_pred<=pred`. If `pred==exp_y`, increment `hit_count`. Increment `tc_count`. Go to CLEAR.
- CLEAR: assert `dnn_reset` for this cycle. If `tc_count==N_TC`, go to DONE; otherwise go to NEXT.
- DONE: assert `batch_done` for this cycle, then go to IDLE.
- `abort` in any non-IDLE state, CLEAR or DONE:
  - next state is CLEAR, which asserts `dnn_reset`;
  - the state after that is IDLE;
  - `batch_done` is not pulsed;
  - counters hold their values.
- `abort` in IDLE: no effect.
- `abort` in CLEAR: CLEAR completes normally, then IDLE.
- `run` while busy: ignored.
- Counters saturate at `N_TC`; they do not wrap.

## Timing
- Reset values: state IDLE; every output 0, including counters, `last_pred` and all pulses.
- All outputs are registered.
- Per test case: 1 (NEXT) + 1 (START) + W (WAIT, ≥1) + N_OUT (ARGMAX) + 1 (SCORE) + 1 (CLEAR) = W+14 cycles at defaults.
- `tc_next` and `dnn_start` are in separate consecutive cycles and never overlap.
- `dnn_reset` always follows scoring; the engine outputs are read before the clear.
- `dnn_out` and `exp_y` must stay stable from the `dnn_done` edge through SCORE.
- Reset assertion mid-batch returns the block to IDLE immediately, with no `dnn_reset` pulse.

## Configuration
- `DNN_SEQ_TIMEOUT_EN` defined:
  - a WAIT-cycle counter runs;
  - at `TIMEOUT_CYC` cycles without a `dnn_done` edge, go to CLEAR;
  - that test case counts in `tc_count` but not in `hit_count`;
  - `timeout_cnt` increments and `last_pred` is set to 0.
- `DNN_SEQ_TIMEOUT_EN` undefined: WAIT has no time limit and `timeout_cnt` is tied to 0.

## Structure
- Package `dnn_seq_pkg` holds:
  - the state enum `dnn_seq_state_t`;
  - the default `N_OUT` and `OUT_W` values;
  - the `score_t` typedef (signed `OUT_W`).
- Sub-module `dnn_argmax_seq`:
  - inputs: `clk`, `rst`, `clr`, `en`, `idx`, `score`;
  - outputs: `pred`, `best`;
  - holds the strict-greater accumulator.
- The FSM and counters live in the top module.

## Test plan
- Basic batch: N_TC=3, engine model asserts done 5 cycles after start, outputs peak at index 3, `exp_y`=4 for all three cases. Required: `hit_count`=3, `tc_count`=3, one `batch_done`, 3 `tc_next`, 3 `dnn_start`, 3 `dnn_reset`.
- Ties and negatives:
  - outputs {5,9,9,…} → `last_pred`=2.
  - all outputs ≤0 with `exp_y`=0 → `last_pred`=0 and this case counts as a hit.
- Mismatch: case 2 of 3 has `exp_y`=7 while the prediction is 4. Required: `hit_count`=2, `tc_count`=3.
- Abort in WAIT during case 2: required `dnn_reset` pulse, then IDLE, no `batch_done`, `tc_count`=1. A following `run` clears the counters and restarts from case 1.
- Stale done: hold `dnn_done` high on entry to WAIT. Required: no progress until a falling edge followed by a rising edge. Separately, `run` pulsed while busy: no effect.
- With the macro, TIMEOUT_CYC=20 and the engine never asserts done:
  - required: `timeout_cnt`=1, `tc_count`=1, `hit_count`=0;
  - CLEAR is entered at exactly 20 WAIT cycles.

Source files
------------

// File: rtl/dnn_seq_pkg.sv
// Shared types for the dnn_relu_fp16 batch sequencer.
// Holds the FSM state encoding, the default engine geometry and the score type.
package dnn_seq_pkg;

   localparam int unsigned DEF_N_OUT = 10;
   localparam int unsigned DEF_OUT_W = 16;

   typedef logic signed [DEF_OUT_W-1:0] score_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_NEXT,
      S_START,
      S_WAIT,
      S_ARGMAX,
      S_SCORE,
      S_CLEAR,
      S_DONE
   } dnn_seq_state_t;

endpackage

// File: rtl/dnn_argmax_seq.sv
// Sequential strict-greater arg-max accumulator, one score per enabled cycle.
// Ports:
//   clk, rst    clock, async active-low reset
//   clr         restart the accumulator (best=0, pred=0)
//   en          consider score at position idx this cycle
//   idx, score  0-based output index and its signed score
//   pred        1-based index of the best positive score so far, 0 if none
//   best        best score so far (starts at 0)
module dnn_argmax_seq
   import dnn_seq_pkg::*;
#(
   parameter int unsigned OUT_W  = DEF_OUT_W,
   parameter int unsigned IDX_W  = 4,
   parameter int unsigned PRED_W = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr,
   input  logic                    en,
   input  logic [IDX_W-1:0]        idx,
   input  logic signed [OUT_W-1:0] score,
   output logic [PRED_W-1:0]       pred,
   output logic signed [OUT_W-1:0] best
);

   // Strict compare: equal scores keep the earlier (lower) index.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pred <= '0;
         best <= '0;
      end else if (clr) begin
         pred <= '0;
         best <= '0;
      end else if (en && (score > best)) begin
         best <= score;
         pred <= PRED_W'(idx) + PRED_W'(1);
      end
   end

endmodule

// File: rtl/dnn_batch_seq.sv
// Batch sequencer around the dnn_relu_fp16 engine: steps the test-case memory,
// starts the engine, waits for its done edge, arg-maxes the outputs and scores
// the prediction against the expected label.
// Ports:
//   clk, rst                   clock, async active-low reset
//   run, abort                 batch start (IDLE only) / batch termination
//   busy, batch_done           activity level / end-of-full-batch pulse
//   tc_next, dnn_start         memory advance pulse / engine start pulse
//   dnn_reset                  engine clear pulse
//   dnn_done, dnn_out, exp_y   engine done level, scores, expected class (1-based)
//   hit_count, tc_count        correct predictions / completed test cases
//   last_pred, timeout_cnt     latest predicted class / watchdog expiries
// Build option: DNN_SEQ_TIMEOUT_EN enables the WAIT watchdog (TIMEOUT_CYC cycles).
module dnn_batch_seq
   import dnn_seq_pkg::*;
#(
   parameter int unsigned N_TC        = 5000,
   parameter int unsigned N_OUT       = DEF_N_OUT,
   parameter int unsigned OUT_W       = DEF_OUT_W,
   parameter int unsigned LBL_W       = 32,
   parameter int unsigned TIMEOUT_CYC = 65536,
   parameter int unsigned CNT_W       = $clog2(N_TC + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    run,
   input  logic                    abort,
   output logic                    busy,
   output logic                    batch_done,
   output logic                    tc_next,
   output logic                    dnn_start,
   output logic                    dnn_reset,
   input  logic                    dnn_done,
   input  logic signed [OUT_W-1:0] dnn_out [N_OUT],
   input  logic [LBL_W-1:0]        exp_y,
   output logic [CNT_W-1:0]        hit_count,
   output logic [CNT_W-1:0]        tc_count,
   output logic [LBL_W-1:0]        last_pred,
   output logic [CNT_W-1:0]        timeout_cnt
);

   localparam int unsigned IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
   localparam logic [CNT_W-1:0] TC_MAX = CNT_W'(N_TC);

   if (TIMEOUT_CYC == 0) begin : g_bad_timeout
      $error("dnn_batch_seq: TIMEOUT_CYC must be at least 1");
   end

   dnn_seq_state_t state, state_nx;

   logic                    done_q;
   logic                    abort_pend;
   logic [IDX_W-1:0]        arg_idx;
   logic [LBL_W-1:0]        pred;
   logic signed [OUT_W-1:0] best;
   logic [LBL_W-1:0]        pred_fin;
   logic                    wait_expired;

   logic done_edge, abort_take, last_idx, score_go, to_go;

   assign done_edge  = dnn_done & ~done_q;
   assign abort_take = abort && (state != S_IDLE) && (state != S_CLEAR);
   assign last_idx   = (arg_idx == IDX_W'(N_OUT - 1));
   assign score_go   = (state == S_SCORE) && !abort_take;
   assign to_go      = (state == S_WAIT) && wait_expired && !done_edge && !abort_take;
   // A prediction only exists once some score beat the initial best of 0.
   assign pred_fin   = (!best[OUT_W-1] && (best != '0)) ? pred : '0;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nx;
   end

   // Next-state logic; abort overrides every non-IDLE state except CLEAR
   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:   if (run) state_nx = S_NEXT;
         S_NEXT:   state_nx = S_START;
         S_START:  state_nx = S_WAIT;
         S_WAIT: begin
            if (done_edge)         state_nx = S_ARGMAX;
            else if (wait_expired) state_nx = S_CLEAR;
         end
         S_ARGMAX: if (last_idx) state_nx = S_SCORE;
         S_SCORE:  state_nx = S_CLEAR;
         S_CLEAR: begin
            if (abort || abort_pend)  state_nx = S_IDLE;
            else if (tc_count == TC_MAX) state_nx = S_DONE;
            else                      state_nx = S_NEXT;
         end
         S_DONE:   state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
      if (abort_take) state_nx = S_CLEAR;
   end

   // Registered outputs decoded from the state being entered
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy       <= 1'b0;
         batch_done <= 1'b0;
         tc_next    <= 1'b0;
         dnn_start  <= 1'b0;
         dnn_reset  <= 1'b0;
      end else begin
         busy       <= (state_nx != S_IDLE);
         batch_done <= (state_nx == S_DONE);
         tc_next    <= (state_nx == S_NEXT);
         dnn_start  <= (state_nx == S_START);
         dnn_reset  <= (state_nx == S_CLEAR);
      end
   end

   // Done-edge history, abort memory across CLEAR, arg-max index
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         done_q     <= 1'b0;
         abort_pend <= 1'b0;
         arg_idx    <= '0;
      end else begin
         done_q <= dnn_done;
         if (abort_take)           abort_pend <= 1'b1;
         else if (state == S_CLEAR) abort_pend <= 1'b0;
         if ((state == S_ARGMAX) && !last_idx) arg_idx <= arg_idx + IDX_W'(1);
         else                                  arg_idx <= '0;
      end
   end

   dnn_argmax_seq #(
      .OUT_W  (OUT_W),
      .IDX_W  (IDX_W),
      .PRED_W (LBL_W)
   ) u_argmax (
      .clk   (clk),
      .rst   (rst),
      .clr   (state == S_START),
      .en    (state == S_ARGMAX),
      .idx   (arg_idx),
      .score (dnn_out[arg_idx]),
      .pred  (pred),
      .best  (best)
   );

   // Batch counters (saturating) and last prediction
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hit_count <= '0;
         tc_count  <= '0;
         last_pred <= '0;
      end else begin
         if ((state == S_IDLE) && run) begin
            hit_count <= '0;
            tc_count  <= '0;
         end
         if (score_go) begin
            last_pred <= pred_fin;
            if ((pred_fin == exp_y) && (hit_count < TC_MAX)) hit_count <= hit_count + CNT_W'(1);
            if (tc_count < TC_MAX) tc_count <= tc_count + CNT_W'(1);
         end
         if (to_go) begin
            last_pred <= '0;
            if (tc_count < TC_MAX) tc_count <= tc_count + CNT_W'(1);
         end
      end
   end

`ifdef DNN_SEQ_TIMEOUT_EN
   localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYC + 1);

   logic [WAIT_W-1:0] wait_cnt;

   // Counts completed WAIT cycles; expiry on the TIMEOUT_CYC-th one
   assign wait_expired = (wait_cnt == WAIT_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_cnt    <= '0;
         timeout_cnt <= '0;
      end else begin
         if (state == S_WAIT) wait_cnt <= wait_cnt + WAIT_W'(1);
         else                 wait_cnt <= '0;
         if (to_go && (timeout_cnt < TC_MAX)) timeout_cnt <= timeout_cnt + CNT_W'(1);
      end
   end
`else
   assign wait_expired = 1'b0;
   assign timeout_cnt  = '0;
`endif

endmodule

// File: tb/tb_dnn_batch_seq.sv
// Directed bench for dnn_batch_seq with a small engine / test-case memory model.
`timescale 1ns/1ps
module tb_dnn_batch_seq;
   import dnn_seq_pkg::*;

   localparam int unsigned N_TC   = 3;
   localparam int unsigned N_OUT  = 10;
   localparam int unsigned OUT_W  = 16;
   localparam int unsigned LBL_W  = 32;
   localparam int unsigned TO_CYC = 20;
   localparam int unsigned CNT_W  = $clog2(N_TC + 1);

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic run = 1'b0;
   logic abort = 1'b0;
   logic dnn_done;
   logic busy, batch_done, tc_next, dnn_start, dnn_reset;
   score_t dnn_out [N_OUT];
   logic [LBL_W-1:0] exp_y;
   logic [CNT_W-1:0] hit_count, tc_count, timeout_cnt;
   logic [LBL_W-1:0] last_pred;

   score_t           tab_out [N_TC][N_OUT];
   logic [LBL_W-1:0] tab_y   [N_TC];

   int n_assert = 0;
   int n_fail   = 0;
   int eng_mode = 0;   // 0 auto (done 5 cycles after start), 1 manual, 2 never
   logic man_done = 1'b0;
   int cnt_next = 0, cnt_start = 0, cnt_reset = 0, cnt_bdone = 0, cnt_busy = 0, cnt_overlap = 0;
   int b_next, b_start, b_reset, b_bdone, b_busy;

   dnn_batch_seq #(
      .N_TC        (N_TC),
      .N_OUT       (N_OUT),
      .OUT_W       (OUT_W),
      .LBL_W       (LBL_W),
      .TIMEOUT_CYC (TO_CYC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .run         (run),
      .abort       (abort),
      .busy        (busy),
      .batch_done  (batch_done),
      .tc_next     (tc_next),
      .dnn_start   (dnn_start),
      .dnn_reset   (dnn_reset),
      .dnn_done    (dnn_done),
      .dnn_out     (dnn_out),
      .exp_y       (exp_y),
      .hit_count   (hit_count),
      .tc_count    (tc_count),
      .last_pred   (last_pred),
      .timeout_cnt (timeout_cnt)
   );

   always #5 clk = ~clk;

   // Engine + test-case memory model and pulse monitor, all on the falling edge
   initial begin : engine_mon
      int case_ptr;
      int eng_cnt;
      case_ptr = 0;
      eng_cnt  = 0;
      dnn_done = 1'b0;
      exp_y    = '0;
      for (int i = 0; i < N_OUT; i++) dnn_out[i] = '0;
      forever begin
         @(negedge clk);
         if (tc_next)              cnt_next++;
         if (dnn_start)            cnt_start++;
         if (dnn_reset)            cnt_reset++;
         if (batch_done)           cnt_bdone++;
         if (busy)                 cnt_busy++;
         if (tc_next && dnn_start) cnt_overlap++;
         if (!busy) case_ptr = 0;
         if (tc_next) begin
            for (int i = 0; i < N_OUT; i++) dnn_out[i] = tab_out[case_ptr % N_TC][i];
            exp_y = tab_y[case_ptr % N_TC];
            case_ptr++;
         end
         if (eng_mode == 0) begin
            if (dnn_reset) begin
               dnn_done = 1'b0;
               eng_cnt  = 0;
            end else if (dnn_start) begin
               eng_cnt = 5;
            end else if (eng_cnt > 0) begin
               eng_cnt--;
               if (eng_cnt == 0) dnn_done = 1'b1;
            end
         end else if (eng_mode == 1) begin
            dnn_done = man_done;
         end else begin
            dnn_done = 1'b0;
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_assert++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start_batch();
      b_next  = cnt_next;
      b_start = cnt_start;
      b_reset = cnt_reset;
      b_bdone = cnt_bdone;
      b_busy  = cnt_busy;
      run = 1'b1;
      cyc(1);
      run = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int k = 0;
      while (busy && (k < 400)) begin
         cyc(1);
         k++;
      end
      chk(tag, 64'(busy), 64'd0);
   endtask

   task automatic wait_tc(input int target, input string tag);
      int k = 0;
      while ((int'(tc_count) != target) && (k < 200)) begin
         cyc(1);
         k++;
      end
      chk(tag, 64'(tc_count), 64'(target));
   endtask

   // Peak 50 at index 3 (class 4), other scores 2*i-6
   task automatic set_base();
      for (int c = 0; c < N_TC; c++) begin
         for (int i = 0; i < N_OUT; i++) tab_out[c][i] = (i == 3) ? score_t'(50) : score_t'(2 * i - 6);
         tab_y[c] = 32'd4;
      end
   endtask

   // Case 0: tie {5,9,9,0..} -> 2; case 1: class 4 vs label 7; case 2: all <= 0 -> 0
   task automatic set_mixed();
      for (int i = 0; i < N_OUT; i++) begin
         tab_out[0][i] = (i == 0) ? score_t'(5) : ((i < 3) ? score_t'(9) : score_t'(0));
         tab_out[1][i] = (i == 3) ? score_t'(50) : score_t'(2 * i - 6);
         tab_out[2][i] = score_t'(-i);
      end
      tab_y[0] = 32'd2;
      tab_y[1] = 32'd7;
      tab_y[2] = 32'd0;
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin : main
      set_base();
      // Reset state
      cyc(3);
      chk("reset_pulses", 64'({busy, batch_done, tc_next, dnn_start, dnn_reset}), 64'd0);
      chk("reset_hit", 64'(hit_count), 64'd0);
      chk("reset_tc", 64'(tc_count), 64'd0);
      chk("reset_last_pred", 64'(last_pred), 64'd0);
      chk("reset_timeout", 64'(timeout_cnt), 64'd0);
      rst = 1'b1;
      cyc(2);
      chk("idle_no_run", 64'(busy), 64'd0);

      // Basic batch: 3 cases, all predicted 4 and labelled 4
      start_batch();
      wait_idle("basic_idle");
      chk("basic_hit", 64'(hit_count), 64'd3);
      chk("basic_tc", 64'(tc_count), 64'd3);
      chk("basic_last_pred", 64'(last_pred), 64'd4);
      chk("basic_tc_next", 64'(cnt_next - b_next), 64'd3);
      chk("basic_dnn_start", 64'(cnt_start - b_start), 64'd3);
      chk("basic_dnn_reset", 64'(cnt_reset - b_reset), 64'd3);
      chk("basic_batch_done", 64'(cnt_bdone - b_bdone), 64'd1);
      chk("basic_busy_cycles", 64'(cnt_busy - b_busy), 64'd58);
      chk("basic_overlap", 64'(cnt_overlap), 64'd0);

      // Ties, mismatch, all non-positive
      set_mixed();
      start_batch();
      wait_tc(1, "mix_tc1");
      chk("tie_last_pred", 64'(last_pred), 64'd2);
      chk("tie_hit", 64'(hit_count), 64'd1);
      wait_tc(2, "mix_tc2");
      chk("mismatch_last_pred", 64'(last_pred), 64'd4);
      chk("mismatch_hit", 64'(hit_count), 64'd1);
      wait_idle("mix_idle");
      chk("neg_last_pred", 64'(last_pred), 64'd0);
      chk("mix_hit", 64'(hit_count), 64'd2);
      chk("mix_tc", 64'(tc_count), 64'd3);
      chk("mix_batch_done", 64'(cnt_bdone - b_bdone), 64'd1);

      // Abort in WAIT of case 2, then restart
      set_base();
      start_batch();
      wait_tc(1, "abort_tc1");
      cyc(3);
      abort = 1'b1;
      cyc(1);
      abort = 1'b0;
      chk("abort_clear_pulse", 64'(dnn_reset), 64'd1);
      chk("abort_clear_busy", 64'(busy), 64'd1);
      cyc(1);
      chk("abort_idle", 64'({busy, dnn_reset}), 64'd0);
      chk("abort_tc", 64'(tc_count), 64'd1);
      chk("abort_hit", 64'(hit_count), 64'd1);
      chk("abort_no_batch_done", 64'(cnt_bdone - b_bdone), 64'd0);
      chk("abort_dnn_reset", 64'(cnt_reset - b_reset), 64'd2);
      cyc(3);
      start_batch();
      chk("restart_tc_clr", 64'(tc_count), 64'd0);
      chk("restart_hit_clr", 64'(hit_count), 64'd0);
      wait_idle("restart_idle");
      chk("restart_hit", 64'(hit_count), 64'd3);
      chk("restart_tc", 64'(tc_count), 64'd3);
      chk("restart_batch_done", 64'(cnt_bdone - b_bdone), 64'd1);

      // Abort while in CLEAR: CLEAR finishes, then IDLE
      start_batch();
      wait_tc(1, "abclr_tc1");
      abort = 1'b1;
      cyc(1);
      abort = 1'b0;
      chk("abclr_idle", 64'(busy), 64'd0);
      chk("abclr_tc", 64'(tc_count), 64'd1);
      chk("abclr_tc_next", 64'(cnt_next - b_next), 64'd1);
      chk("abclr_no_batch_done", 64'(cnt_bdone - b_bdone), 64'd0);

      // Stale done level on WAIT entry, and run while busy
      man_done = 1'b1;
      eng_mode = 1;
      cyc(2);
      start_batch();
      cyc(22);
      run = 1'b1;
      cyc(1);
      run = 1'b0;
      chk("stale_no_progress", 64'(tc_count), 64'd0);
      chk("stale_no_clear", 64'(cnt_reset - b_reset), 64'd0);
      chk("stale_busy", 64'(busy), 64'd1);
      man_done = 1'b0;
      cyc(2);
      man_done = 1'b1;
      cyc(11);
      chk("stale_edge_score", 64'(tc_count), 64'd0);
      cyc(1);
      chk("stale_edge_tc", 64'(tc_count), 64'd1);
      chk("stale_edge_clear", 64'(dnn_reset), 64'd1);
      eng_mode = 0;
      wait_idle("stale_idle");
      chk("stale_hit", 64'(hit_count), 64'd3);
      chk("stale_tc", 64'(tc_count), 64'd3);
      cyc(5);
      chk("run_busy_ignored", 64'(busy), 64'd0);
      chk("run_busy_batch_done", 64'(cnt_bdone - b_bdone), 64'd1);

`ifdef DNN_SEQ_TIMEOUT_EN
      // Watchdog: engine never finishes
      eng_mode = 2;
      cyc(2);
      start_batch();
      cyc(2);
      cyc(19);
      chk("to_wait20_no_clear", 64'(dnn_reset), 64'd0);
      chk("to_wait20_tc", 64'(tc_count), 64'd0);
      cyc(1);
      chk("to_clear", 64'(dnn_reset), 64'd1);
      chk("to_tc", 64'(tc_count), 64'd1);
      chk("to_hit", 64'(hit_count), 64'd0);
      chk("to_timeout_cnt", 64'(timeout_cnt), 64'd1);
      chk("to_last_pred", 64'(last_pred), 64'd0);
      abort = 1'b1;
      cyc(1);
      abort = 1'b0;
      chk("to_abort_idle", 64'(busy), 64'd0);
      eng_mode = 0;
`else
      chk("timeout_tied_zero", 64'(timeout_cnt), 64'd0);
`endif

      // Reset in mid-batch: immediate IDLE, no clear pulse
      start_batch();
      cyc(8);
      chk("midrst_busy_before", 64'(busy), 64'd1);
      rst = 1'b0;
      #1;
      chk("midrst_outputs", 64'({busy, batch_done, tc_next, dnn_start, dnn_reset}), 64'd0);
      chk("midrst_counters", 64'({hit_count, tc_count, last_pred}), 64'd0);
      cyc(2);
      rst = 1'b1;
      cyc(5);
      chk("midrst_no_dnn_reset", 64'(cnt_reset - b_reset), 64'd0);
      chk("midrst_stays_idle", 64'(busy), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
